// File: rtl/vga_timing_pkg.sv
// Default 800x600 @ 72 Hz raster timing (50 MHz pixel clock) and counter widths.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 800;
  localparam int unsigned VGA_H_FP     = 56;
  localparam int unsigned VGA_H_SYNC   = 120;
  localparam int unsigned VGA_H_BP     = 64;
  localparam int unsigned VGA_V_ACTIVE = 600;
  localparam int unsigned VGA_V_FP     = 37;
  localparam int unsigned VGA_V_SYNC   = 6;
  localparam int unsigned VGA_V_BP     = 23;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  localparam int unsigned HCNT_W  = 11;
  localparam int unsigned VCNT_W  = 10;
  localparam int unsigned COORD_W = 10;

  localparam int unsigned VGA_PIPE_DELAY = 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered blanking and sync decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  parameter int unsigned WIDTH  = HCNT_W,
  parameter logic        POL    = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_advance,
  output logic [WIDTH-1:0] o_count,
  output logic             o_notactive,
  output logic             o_sync,
  output logic             o_wrap_c
);

  localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC - 1;

  localparam logic [WIDTH-1:0] L_LAST       = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] L_ACTIVE     = WIDTH'(ACTIVE);
  localparam logic [WIDTH-1:0] L_SYNC_START = WIDTH'(SYNC_START);
  localparam logic [WIDTH-1:0] L_SYNC_END   = WIDTH'(SYNC_END);

  logic [WIDTH-1:0] r_count;
  logic             r_notactive;
  logic             r_sync;
  logic [WIDTH-1:0] w_next;

  // Next position: hold unless advancing, wrap after the last position.
  always_comb begin
    w_next = r_count;
    if (i_advance) begin
      if (r_count == L_LAST) w_next = '0;
      else                   w_next = r_count + WIDTH'(1);
    end
  end

  assign o_wrap_c = i_advance && (r_count == L_LAST);

  // Count and decode registered together so flags line up with the count they describe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count     <= L_LAST;
      r_notactive <= 1'b1;
      r_sync      <= ~POL;
    end else begin
      r_count     <= w_next;
      r_notactive <= (w_next >= L_ACTIVE);
      r_sync      <= ((w_next >= L_SYNC_START) && (w_next <= L_SYNC_END)) ? POL : ~POL;
    end
  end

  assign o_count     = r_count;
  assign o_notactive = r_notactive;
  assign o_sync      = r_sync;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing source: coordinates, blanking, frame pulse and delayed syncs.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter logic        SYNC_POL   = 1'b1,
  parameter int unsigned PIPE_DELAY = VGA_PIPE_DELAY
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               hnotactive,
  output logic               vnotactive,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  localparam logic [HCNT_W-1:0] L_H_ACTIVE = HCNT_W'(H_ACTIVE);
  localparam logic [VCNT_W-1:0] L_V_ACTIVE = VCNT_W'(V_ACTIVE);

  logic [HCNT_W-1:0]  w_hcnt;
  logic [VCNT_W-1:0]  w_vcnt;
  logic [HCNT_W-1:0]  w_hnext;
  logic [VCNT_W-1:0]  w_vnext;
  logic               w_hwrap;
  logic               w_vwrap;
  logic               w_hsync_raw;
  logic               w_vsync_raw;
  logic [COORD_W-1:0] r_row;
  logic [COORD_W-1:0] r_col;
  logic               r_frame_start;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .WIDTH  (HCNT_W),
    .POL    (SYNC_POL)
  ) u_hcnt (
    .i_clk       (CLK),
    .i_rst_n     (RST),
    .i_advance   (1'b1),
    .o_count     (w_hcnt),
    .o_notactive (hnotactive),
    .o_sync      (w_hsync_raw),
    .o_wrap_c    (w_hwrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .WIDTH  (VCNT_W),
    .POL    (SYNC_POL)
  ) u_vcnt (
    .i_clk       (CLK),
    .i_rst_n     (RST),
    .i_advance   (w_hwrap),
    .o_count     (w_vcnt),
    .o_notactive (vnotactive),
    .o_sync      (w_vsync_raw),
    .o_wrap_c    (w_vwrap)
  );

  // Next raster position, so the coordinate registers track the counters with no lag.
  always_comb begin
    w_hnext = w_hcnt + HCNT_W'(1);
    w_vnext = w_vcnt;
    if (w_hwrap) begin
      w_hnext = '0;
      w_vnext = w_vcnt + VCNT_W'(1);
    end
    if (w_vwrap) w_vnext = '0;
  end

  // Coordinates zeroed outside active video; frame pulse on the wrap into (0,0).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_row         <= '0;
      r_col         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_row         <= (w_hnext < L_H_ACTIVE) ? COORD_W'(w_hnext) : '0;
      r_col         <= (w_vnext < L_V_ACTIVE) ? COORD_W'(w_vnext) : '0;
      r_frame_start <= w_vwrap;
    end
  end

  assign row         = r_row;
  assign col         = r_col;
  assign frame_start = r_frame_start;

  // Sync delay line matching the downstream RGB register.
  if (PIPE_DELAY == 0) begin : g_no_delay
    assign hsync = w_hsync_raw;
    assign vsync = w_vsync_raw;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] r_hs_pipe;
    logic [PIPE_DELAY-1:0] r_vs_pipe;

    // Shift both syncs one stage per clock, idle at the deasserted level.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_hs_pipe <= {PIPE_DELAY{~SYNC_POL}};
        r_vs_pipe <= {PIPE_DELAY{~SYNC_POL}};
      end else begin
        r_hs_pipe[0] <= w_hsync_raw;
        r_vs_pipe[0] <= w_vsync_raw;
        for (int k = 1; k < int'(PIPE_DELAY); k++) begin
          r_hs_pipe[k] <= r_hs_pipe[k-1];
          r_vs_pipe[k] <= r_vs_pipe[k-1];
        end
      end
    end

    assign hsync = r_hs_pipe[PIPE_DELAY-1];
    assign vsync = r_vs_pipe[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: four vga_sync_gen instances against an arithmetic raster model.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  // Reduced raster so whole frames fit in a short run.
  localparam int unsigned SH_A = 16;
  localparam int unsigned SH_F = 3;
  localparam int unsigned SH_S = 4;
  localparam int unsigned SH_B = 5;
  localparam int unsigned SV_A = 10;
  localparam int unsigned SV_F = 2;
  localparam int unsigned SV_S = 3;
  localparam int unsigned SV_B = 2;

  localparam int NDUT = 4;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic       hna;
    logic       vna;
    logic       hs;
    logic       vs;
    logic       fs;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic [9:0] row [NDUT];
  logic [9:0] col [NDUT];
  logic       hna [NDUT];
  logic       vna [NDUT];
  logic       hs  [NDUT];
  logic       vs  [NDUT];
  logic       fs  [NDUT];

  longint k;       // raster step since reset release; -1 while in reset
  int     n_cmp;
  int     n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: full 800x600 timing, delay 1, positive syncs
  vga_sync_gen u_dflt (
    .CLK(clk), .RST(rst_n), .row(row[0]), .col(col[0]), .hnotactive(hna[0]),
    .vnotactive(vna[0]), .hsync(hs[0]), .vsync(vs[0]), .frame_start(fs[0])
  );

  // 1: small raster, delay 1, positive syncs
  vga_sync_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_POL(1'b1), .PIPE_DELAY(1)
  ) u_sm_d1 (
    .CLK(clk), .RST(rst_n), .row(row[1]), .col(col[1]), .hnotactive(hna[1]),
    .vnotactive(vna[1]), .hsync(hs[1]), .vsync(vs[1]), .frame_start(fs[1])
  );

  // 2: small raster, no delay, negative syncs
  vga_sync_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_POL(1'b0), .PIPE_DELAY(0)
  ) u_sm_d0n (
    .CLK(clk), .RST(rst_n), .row(row[2]), .col(col[2]), .hnotactive(hna[2]),
    .vnotactive(vna[2]), .hsync(hs[2]), .vsync(vs[2]), .frame_start(fs[2])
  );

  // 3: small raster, delay 3, positive syncs
  vga_sync_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_POL(1'b1), .PIPE_DELAY(3)
  ) u_sm_d3 (
    .CLK(clk), .RST(rst_n), .row(row[3]), .col(col[3]), .hnotactive(hna[3]),
    .vnotactive(vna[3]), .hsync(hs[3]), .vsync(vs[3]), .frame_start(fs[3])
  );

  // Expected outputs at raster step st: position from plain division, syncs from step st-pd.
  function automatic obs_t model(input longint ha, input longint hf, input longint hsw,
                                 input longint hb, input longint va, input longint vf,
                                 input longint vsw, input longint vb, input logic pol,
                                 input longint pd, input longint st);
    obs_t   o;
    longint ht, vt, h, v, j, hj, vj;
    ht    = ha + hf + hsw + hb;
    vt    = va + vf + vsw + vb;
    o.row = 10'd0;
    o.col = 10'd0;
    o.hna = 1'b1;
    o.vna = 1'b1;
    o.hs  = ~pol;
    o.vs  = ~pol;
    o.fs  = 1'b0;
    if (st >= 0) begin
      h     = st % ht;
      v     = (st / ht) % vt;
      o.row = (h < ha) ? 10'(h) : 10'd0;
      o.col = (v < va) ? 10'(v) : 10'd0;
      o.hna = (h >= ha);
      o.vna = (v >= va);
      o.fs  = (h == 0) && (v == 0);
      j = st - pd;
      if (j >= 0) begin
        hj = j % ht;
        vj = (j / ht) % vt;
        if (hj >= ha + hf && hj < ha + hf + hsw) o.hs = pol;
        if (vj >= va + vf && vj < va + vf + vsw) o.vs = pol;
      end
    end
    return o;
  endfunction

  function automatic obs_t expect_for(input int i, input longint st);
    obs_t o;
    case (i)
      0:       o = model(800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1, st);
      1:       o = model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1, 1, st);
      2:       o = model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b0, 0, st);
      default: o = model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1, 3, st);
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got row=%0d col=%0d hna=%b vna=%b hs=%b vs=%b fs=%b, want row=%0d col=%0d hna=%b vna=%b hs=%b vs=%b fs=%b",
               tag, got.row, got.col, got.hna, got.vna, got.hs, got.vs, got.fs,
               want.row, want.col, want.hna, want.vna, want.hs, want.vs, want.fs);
    end
  endtask

  task automatic check_all();
    obs_t got;
    for (int i = 0; i < NDUT; i++) begin
      got = '{row: row[i], col: col[i], hna: hna[i], vna: vna[i], hs: hs[i], vs: vs[i], fs: fs[i]};
      chk($sformatf("dut%0d k=%0d", i, k), got, expect_for(i, k));
    end
  endtask

  // Advance n clocks with reset released, checking every cycle away from the edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_all();
    end
  endtask

  // Assert reset between edges, confirm it acts at once, hold a few clocks, release.
  task automatic pulse_reset(input int hold);
    #2;
    rst_n = 1'b0;
    k     = -1;
    #1;
    check_all();
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    k     = -1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Three full default lines, several small frames.
    run(3200);

    // Mid-frame resets at random points and random hold lengths.
    for (int s = 0; s < 5; s++) begin
      pulse_reset(int'($urandom_range(1, 4)));
      run(int'($urandom_range(600, 3000)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

- Generates VGA raster timing for 800x600 @ 72 Hz from the 50 MHz system clock, one pixel per clock.
- Outputs per-pixel coordinates (`row` = horizontal, `col` = vertical) and blanking flags to the pixel-colour stage.
- Drives `hsync`/`vsync` to the connector, delayed to line up with that stage's registered RGB.
- It is the source end of the `row`/`col`/`vnotactive` interface that the display block consumes.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 56, horizontal front porch (clocks)
- `H_SYNC`, 120, horizontal sync width
- `H_BP`, 64, horizontal back porch
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 37, vertical front porch (lines)
- `V_SYNC`, 6, vertical sync width
- `V_BP`, 23, vertical back porch
- `SYNC_POL`, 1, asserted level of `hsync`/`vsync`
- `PIPE_DELAY`, 1, extra register stages on `hsync`/`vsync` (0..3)

Ports:
- `CLK` in 1: pixel clock; one clock domain only.
- `RST` in 1: reset, asynchronous, active-low.
- `row` out 10: horizontal pixel index during active video, else 0.
- `col` out 10: vertical line index during active lines, else 0.
- `hnotactive` out 1: high in horizontal blanking.
- `vnotactive` out 1: high in vertical blanking.
- `hsync` out 1: horizontal sync, delayed by `PIPE_DELAY`.
- `vsync` out 1: vertical sync, delayed by `PIPE_DELAY`.
- `frame_start` out 1: one-clock pulse at pixel (0,0).

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1040; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 666.
- Counter widths: `hcnt` 11 bits, `vcnt` 10 bits.
- `hcnt` increments every clock. At H_TOTAL-1 it wraps to 0 and `vcnt` advances.
- `vcnt` wraps from V_TOTAL-1 to 0 on the same clock that `hcnt` wraps.
- Active video is `hcnt` < H_ACTIVE and `vcnt` < V_ACTIVE.
- `row` = `hcnt[9:0]` when `hcnt` < H_ACTIVE, else 0.
- `col` = `vcnt` when `vcnt` < V_ACTIVE, else 0.
- `hnotactive` = (`hcnt` >= H_ACTIVE); `vnotactive` = (`vcnt` >= V_ACTIVE).
- Raw hsync is asserted for `hcnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [856, 975].
- Raw vsync is asserted for `vcnt` in [637, 642], for the whole of each of those lines.
- Asserted sync level is `SYNC_POL`; deasserted level is `~SYNC_POL`.
- `frame_start` = 1 exactly when (`hcnt`,`vcnt`) = (0,0).
- All outputs are registered and reflect the counter value held in the same cycle; decode from the next-count value.

## Timing
- Reset (RST low, async):
  - `hcnt` = H_TOTAL-1, `vcnt` = V_TOTAL-1.
  - `row` = `col` = 0, `hnotactive` = `vnotactive` = 1, `frame_start` = 0.
  - `hsync`, `vsync` and every delay stage = `~SYNC_POL`.
- First rising edge after reset release: counters wrap to (0,0); `frame_start` = 1, `row` = `col` = 0, both notactive flags 0.
- Reset asserted mid-frame: all state returns to the reset values immediately; no partial line survives.
- Coordinate latency: 0 relative to the counters.
- Sync latency: `hsync`/`vsync` lag `row`/`col` by exactly `PIPE_DELAY` clocks, matching the one-cycle RGB register downstream.
- With `PIPE_DELAY` = 0, syncs are aligned with coordinates.
- Line period is 1040 clocks; frame period is 692,640 clocks; `frame_start` fires once per frame.
- Line wrap and frame wrap on the same clock: the `vcnt` update and the `hcnt` wrap take effect together; no extra cycle is inserted.
- `vnotactive` changes only on `hcnt` wrap clocks.

## Structure
- Package `vga_timing_pkg`: the 800x600@72 default constants, H_TOTAL/V_TOTAL, and the derived sync start/end positions.
- Sub-module `vga_axis_counter`:
  - Parameters: active, fp, sync, bp, width.
  - Inputs: `advance`. Outputs: `count`, `notactive`, raw `sync`, `wrap`.
  - Two instances: horizontal with `advance` = 1; vertical with `advance` = horizontal `wrap`.
- The top level adds the coordinate zeroing, the `frame_start` decode, and the `PIPE_DELAY` sync shift register.

## Test plan
- **Reset release**: hold RST low, then release → first edge: `frame_start` = 1, `row` = 0, `col` = 0; next edge: `row` = 1, `frame_start` = 0.
- **Horizontal decode, line 0**: `row` counts 0..799 then holds 0. `hnotactive` rises at `hcnt` 800. `hsync` (PIPE_DELAY 1) is high from clock 857 through 976 inclusive, measured from `frame_start`.
- **Vertical decode**: `col` = 599 on line 599, 0 from line 600. `vnotactive` rises on the first clock of line 600. `vsync` is high for exactly 6×1040 clocks starting at line 637 (+1 clock delay).
- **Frame wrap**: at (1039,665) → next clock (0,0); `frame_start` repeats every 692,640 clocks; `vnotactive` falls on the same clock.
- **Mid-frame reset**: assert RST at (400,300) for 3 clocks → outputs show reset values asynchronously; after release, the sequence restarts exactly as in the reset-release scenario.
- **Parameter variants**: `PIPE_DELAY` = 0 and 3, `SYNC_POL` = 0 → sync edges shift by 0 / 3 clocks relative to the default decode, with inverted level where `SYNC_POL` = 0; coordinates unchanged.
